// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer write path.
//   FB_WORD_BYTES / FB_BEATS / FB_ADDR_W : word geometry and BRAM byte-address width
//   fb_wr_entry_t : one queued store {addr, data, mask} (71 bits)
//   fb_state_t    : serialiser states (IDLE, then one state per 2-byte beat)
//   fb_beat_state : maps a beat index (0..2) to its serialiser state
package fb_pkg;

  localparam int FB_WORD_BYTES = 6;
  localparam int FB_BEATS      = 3;
  localparam int FB_ADDR_W     = 17;

  typedef struct packed {
    logic [FB_ADDR_W-1:0]       addr;
    logic [8*FB_WORD_BYTES-1:0] data;
    logic [FB_WORD_BYTES-1:0]   mask;
  } fb_wr_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } fb_state_t;

  function automatic fb_state_t fb_beat_state(input logic [1:0] beat);
    fb_state_t s;
    case (beat)
      2'd0:    s = B0;
      2'd1:    s = B1;
      default: s = (FB_BEATS == 3) ? B2 : IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO of fb_wr_entry_t records.
//   clk_75mhz_internal, rst : clock and synchronous active-high reset
//   push, push_entry        : enqueue (ignored while full)
//   pop                     : dequeue (ignored while empty)
//   head                    : entry at the read pointer, valid while !empty
//   full, empty, count      : occupancy, all derived from registered state
// The head is read combinationally so the serialiser can launch beat 0 of a
// word on the same edge it pops it; the array is only DEPTH entries deep.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_75mhz_internal,
  input  logic                     rst,
  input  logic                     push,
  input  fb_wr_entry_t             push_entry,
  input  logic                     pop,
  output fb_wr_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fb_wr_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset: entries are only observed behind count_reg.
  always_ff @(posedge clk_75mhz_internal) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_75mhz_internal) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_packer.sv
// fb_write_packer: buffers 48-bit framebuffer stores and serialises each into
// three 2-byte dual-port BRAM write beats (bytes 2k/2k+1 at A+2k/A+2k+1).
//   clk_75mhz_internal, rst : BRAM-domain clock, synchronous active-high reset
//   wr_valid/wr_ready       : store handshake; wr_addr even, wr_data, wr_mask
//   hold                    : arbiter stall, sampled at each edge
//   addra/dina/wea          : port A (even byte), registered
//   addrb/dinb/web          : port B (addra+1), registered
//   busy                    : FIFO non-empty or a word in flight
//   err_unaligned           : sticky flag for a dropped odd-address store
module fb_write_packer
  import fb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17
) (
  input  logic                       clk_75mhz_internal,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [8*FB_WORD_BYTES-1:0] wr_data,
  input  logic [FB_WORD_BYTES-1:0]   wr_mask,
  input  logic                       hold,
  output logic [ADDR_W-1:0]          addra,
  output logic [7:0]                 dina,
  output logic                       wea,
  output logic [ADDR_W-1:0]          addrb,
  output logic [7:0]                 dinb,
  output logic                       web,
  output logic                       busy,
  output logic                       err_unaligned
);

  fb_wr_entry_t            push_entry;
  fb_wr_entry_t            head;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  // Odd-address stores complete the handshake but are never queued.
  assign wr_ready   = ~fifo_full;
  assign fifo_push  = wr_valid & wr_ready & ~wr_addr[0];
  assign push_entry = '{addr: FB_ADDR_W'(wr_addr), data: wr_data, mask: wr_mask};

  fb_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_75mhz_internal (clk_75mhz_internal),
    .rst                (rst),
    .push               (fifo_push),
    .push_entry         (push_entry),
    .pop                (fifo_pop),
    .head               (head),
    .full               (fifo_full),
    .empty              (fifo_empty),
    .count              (fifo_count)
  );

  fb_state_t         state_reg;
  logic              pend_reg;     // beat shown by state_reg was stalled, not yet written
  fb_wr_entry_t      cur_reg;      // word currently being serialised
  logic [ADDR_W-1:0] addra_reg;
  logic [ADDR_W-1:0] addrb_reg;
  logic [7:0]        dina_reg;
  logic [7:0]        dinb_reg;
  logic              wea_reg;
  logic              web_reg;
  logic              err_reg;

  // Select the next beat to launch: a stalled beat is retried, otherwise the
  // following beat, and after beat 2 (or from IDLE) beat 0 of the FIFO head.
  logic         have_beat;
  logic         from_head;
  logic [1:0]   nb;
  fb_wr_entry_t src;

  always_comb begin
    have_beat = 1'b0;
    from_head = 1'b0;
    nb        = 2'd0;
    case (state_reg)
      IDLE: begin
        have_beat = ~fifo_empty;
        from_head = 1'b1;
      end
      B0: begin
        have_beat = 1'b1;
        nb        = pend_reg ? 2'd0 : 2'd1;
      end
      B1: begin
        have_beat = 1'b1;
        nb        = pend_reg ? 2'd1 : 2'd2;
      end
      default: begin
        if (pend_reg) begin
          have_beat = 1'b1;
          nb        = 2'd2;
        end else begin
          have_beat = ~fifo_empty;
          from_head = 1'b1;
        end
      end
    endcase
  end

  assign src      = from_head ? head : cur_reg;
  assign fifo_pop = have_beat & from_head & ~hold;

  logic [5:0]        lo_bit;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_byte_a;
  logic [7:0]        beat_byte_b;
  logic              beat_we_a;
  logic              beat_we_b;

  assign lo_bit      = {nb, 4'b0000};
  assign beat_addr   = ADDR_W'(src.addr) + ADDR_W'({nb, 1'b0});
  assign beat_byte_a = src.data[lo_bit +: 8];
  assign beat_byte_b = src.data[lo_bit + 6'd8 +: 8];
  assign beat_we_a   = src.mask[{nb, 1'b0}];
  assign beat_we_b   = src.mask[{nb, 1'b1}];

  always_ff @(posedge clk_75mhz_internal) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 1'b0;
      cur_reg   <= '0;
      addra_reg <= '0;
      addrb_reg <= '0;
      dina_reg  <= '0;
      dinb_reg  <= '0;
      wea_reg   <= 1'b0;
      web_reg   <= 1'b0;
    end else begin
      wea_reg <= 1'b0;
      web_reg <= 1'b0;
      if (!have_beat) begin
        state_reg <= IDLE;
        pend_reg  <= 1'b0;
      end else if (hold) begin
        if (from_head) begin
          // Nothing popped while stalled; the head stays queued.
          state_reg <= IDLE;
          pend_reg  <= 1'b0;
        end else begin
          // Park on the pending beat with enables low; it is retried later.
          state_reg <= fb_beat_state(nb);
          pend_reg  <= 1'b1;
          addra_reg <= beat_addr;
          addrb_reg <= beat_addr + ADDR_W'(1);
          dina_reg  <= beat_byte_a;
          dinb_reg  <= beat_byte_b;
        end
      end else begin
        state_reg <= fb_beat_state(nb);
        pend_reg  <= 1'b0;
        addra_reg <= beat_addr;
        addrb_reg <= beat_addr + ADDR_W'(1);
        dina_reg  <= beat_byte_a;
        dinb_reg  <= beat_byte_b;
        wea_reg   <= beat_we_a;
        web_reg   <= beat_we_b;
        if (from_head) begin
          cur_reg <= head;
        end
      end
    end
  end

  always_ff @(posedge clk_75mhz_internal) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (wr_valid && wr_ready && wr_addr[0]) begin
      err_reg <= 1'b1;
    end
  end

  assign addra         = addra_reg;
  assign addrb         = addrb_reg;
  assign dina          = dina_reg;
  assign dinb          = dinb_reg;
  assign wea           = wea_reg;
  assign web           = web_reg;
  assign busy          = (fifo_count != '0) | (state_reg != IDLE);
  assign err_unaligned = err_reg;

endmodule

// File: tb/tb_fb_write_packer.sv
// tb_fb_write_packer: self-checking bench for fb_write_packer.
// Table of single-word vectors with exact beat timing, hand-written sequences
// for back-to-back, hold, unaligned and mid-word reset, then a randomized run
// checked against a byte-level reference list built from accepted words.
module tb_fb_write_packer;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [47:0] wr_data;
  logic [5:0]  wr_mask;
  logic        hold;
  logic [16:0] addra;
  logic [7:0]  dina;
  logic        wea;
  logic [16:0] addrb;
  logic [7:0]  dinb;
  logic        web;
  logic        busy;
  logic        err_unaligned;

  fb_write_packer #(
    .DEPTH  (4),
    .ADDR_W (17)
  ) dut (
    .clk_75mhz_internal (clk),
    .rst                (rst),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_mask            (wr_mask),
    .hold               (hold),
    .addra              (addra),
    .dina               (dina),
    .wea                (wea),
    .addrb              (addrb),
    .dinb               (dinb),
    .web                (web),
    .busy               (busy),
    .err_unaligned      (err_unaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level observation of the BRAM ports and the reference list.
  logic [24:0] obs_q[$];
  logic [24:0] exp_q[$];
  int          beat_cnt    = 0;
  int          cyc         = 0;
  int          first_beat  = -1;
  int          last_beat   = -1;
  logic        hold_at_edge = 1'b0;

  always @(posedge clk) hold_at_edge <= hold;

  always @(negedge clk) begin
    cyc++;
    if (wea) obs_q.push_back({addra, dina});
    if (web) obs_q.push_back({addrb, dinb});
    if (wea || web) begin
      beat_cnt++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (hold_at_edge && !rst) chk("no write after held edge", 64'({wea, web}), 64'(0));
  end

  // Reference: every enabled byte k of an accepted aligned word lands at A+k.
  task automatic add_exp(input logic [16:0] a, input logic [47:0] d, input logic [5:0] m);
    for (int k = 0; k < 6; k++) begin
      if (m[k]) exp_q.push_back({17'(a + 17'(k)), d[8*k +: 8]});
    end
  endtask

  task automatic cmp_queues(input string name);
    chk({name, " byte count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({name, " byte"}, 64'(obs_q[i]), 64'(exp_q[i]));
    end
    $display("%s: %0d bytes observed, %0d expected", name, obs_q.size(), exp_q.size());
  endtask

  // Called at a negedge; leaves inputs idle at the negedge after the transfer edge.
  task automatic push_word(input logic [16:0] a, input logic [47:0] d, input logic [5:0] m);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, " reaches idle"}, 64'(busy), 64'(0));
  endtask

  typedef struct packed {
    logic [16:0]      addr;
    logic [47:0]      data;
    logic [5:0]       mask;
    logic [2:0][16:0] exp_addra;
    logic [2:0][16:0] exp_addrb;
    logic [5:0]       exp_we;
  } vec_t;

  vec_t vecs [5];

  logic [47:0] w_data [5];
  logic        rdy;
  logic        saw_not_ready;
  logic        any_unal;
  int          nsent;
  int          snap;
  logic [16:0] ra;
  logic [47:0] rd;
  logic [5:0]  rm;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 17'h00100, data: 48'h665544332211, mask: 6'h3F,
                exp_addra: {17'h00104, 17'h00102, 17'h00100},
                exp_addrb: {17'h00105, 17'h00103, 17'h00101}, exp_we: 6'b111111};
    vecs[1] = '{addr: 17'h1FFFE, data: 48'hAABBCCDDEEFF, mask: 6'b100101,
                exp_addra: {17'h00002, 17'h00000, 17'h1FFFE},
                exp_addrb: {17'h00003, 17'h00001, 17'h1FFFF}, exp_we: 6'b100101};
    vecs[2] = '{addr: 17'h00200, data: 48'h0123456789AB, mask: 6'h00,
                exp_addra: {17'h00204, 17'h00202, 17'h00200},
                exp_addrb: {17'h00205, 17'h00203, 17'h00201}, exp_we: 6'b000000};
    vecs[3] = '{addr: 17'h0ABCE, data: 48'hDEADBEEFCAFE, mask: 6'b011010,
                exp_addra: {17'h0ABD2, 17'h0ABD0, 17'h0ABCE},
                exp_addrb: {17'h0ABD3, 17'h0ABD1, 17'h0ABCF}, exp_we: 6'b011010};
    vecs[4] = '{addr: 17'h1FFFC, data: 48'h102030405060, mask: 6'h3F,
                exp_addra: {17'h00000, 17'h1FFFE, 17'h1FFFC},
                exp_addrb: {17'h00001, 17'h1FFFF, 17'h1FFFD}, exp_we: 6'b111111};

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    hold     = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({addra, addrb, dina, dinb, wea, web}), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset err", 64'(err_unaligned), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 64'(wr_ready), 64'(1));
    $display("reset: busy=%0d ready=%0d", busy, wr_ready);

    // ---------------- table-driven single words ----------------
    for (int v = 0; v < 5; v++) begin
      push_word(vecs[v].addr, vecs[v].data, vecs[v].mask);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("vec%0d beat%0d", v, k),
            64'({addra, addrb, dina, dinb, wea, web}),
            64'({vecs[v].exp_addra[k], vecs[v].exp_addrb[k],
                 vecs[v].data[16*k +: 8], vecs[v].data[16*k+8 +: 8],
                 vecs[v].exp_we[2*k], vecs[v].exp_we[2*k+1]}));
      end
      chk($sformatf("vec%0d busy during B2", v), 64'(busy), 64'(1));
      @(negedge clk);
      chk($sformatf("vec%0d idle after B2", v), 64'({busy, wea, web}), 64'(0));
      $display("vec%0d: addr=%h data=%h mask=%b done", v, vecs[v].addr, vecs[v].data, vecs[v].mask);
    end

    // ---------------- back-to-back, FIFO fills under hold ----------------
    obs_q.delete();
    exp_q.delete();
    beat_cnt      = 0;
    first_beat    = -1;
    last_beat     = -1;
    saw_not_ready = 1'b0;
    nsent         = 0;
    hold          = 1'b1;
    for (int i = 0; i < 5; i++) w_data[i] = {16'($urandom), $urandom};
    for (int n = 0; n < 60 && nsent < 5; n++) begin
      wr_valid = 1'b1;
      wr_addr  = 17'h01000 + 17'(6 * nsent);
      wr_data  = w_data[nsent];
      wr_mask  = 6'h3F;
      rdy      = wr_ready;
      if (!rdy) begin
        saw_not_ready = 1'b1;
        hold          = 1'b0;
      end
      @(posedge clk);
      if (rdy) begin
        add_exp(wr_addr, wr_data, wr_mask);
        nsent++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    hold     = 1'b0;
    wait_idle("b2b", 100);
    chk("b2b words sent", 64'(nsent), 64'(5));
    chk("b2b ready dropped when full", 64'(saw_not_ready), 64'(1));
    chk("b2b enabled beats", 64'(beat_cnt), 64'(15));
    chk("b2b no gap", 64'(last_beat - first_beat), 64'(14));
    cmp_queues("b2b");

    // ---------------- hold for 4 cycles starting at B1 ----------------
    beat_cnt = 0;
    push_word(17'h02000, 48'hF6F5F4F3F2F1, 6'h3F);
    @(negedge clk);
    chk("hold B0", 64'({addra, dina, wea, web}), 64'({17'h02000, 8'hF1, 1'b1, 1'b1}));
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold stall cycle %0d", i), 64'({wea, web}), 64'(0));
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold B1 redriven", 64'({addra, addrb, dina, dinb, wea, web}),
        64'({17'h02002, 17'h02003, 8'hF3, 8'hF4, 1'b1, 1'b1}));
    @(negedge clk);
    chk("hold B2", 64'({addra, addrb, dina, dinb, wea, web}),
        64'({17'h02004, 17'h02005, 8'hF5, 8'hF6, 1'b1, 1'b1}));
    wait_idle("hold", 20);
    chk("hold enabled beats", 64'(beat_cnt), 64'(3));
    $display("hold: %0d enabled beats", beat_cnt);

    // ---------------- unaligned store ----------------
    obs_q.delete();
    exp_q.delete();
    snap = beat_cnt;
    push_word(17'h00011, 48'h123456789ABC, 6'h3F);
    chk("unaligned err set", 64'(err_unaligned), 64'(1));
    chk("unaligned not queued", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("unaligned no write", 64'(beat_cnt - snap), 64'(0));
    push_word(17'h00020, 48'hA5A4A3A2A1A0, 6'h3F);
    add_exp(17'h00020, 48'hA5A4A3A2A1A0, 6'h3F);
    wait_idle("unaligned follow-up", 20);
    chk("unaligned err sticky", 64'(err_unaligned), 64'(1));
    cmp_queues("unaligned follow-up");

    // ---------------- reset mid-word ----------------
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 17'h03000 + 17'(6 * i);
      wr_data  = {16'($urandom), $urandom};
      wr_mask  = 6'h3F;
      @(posedge clk);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("midreset in B1", 64'({addra, wea, busy}), 64'({17'h03002, 1'b1, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    chk("midreset enables low", 64'({wea, web}), 64'(0));
    chk("midreset busy low", 64'(busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midreset ready", 64'(wr_ready), 64'(1));
    chk("midreset err cleared", 64'(err_unaligned), 64'(0));
    snap = beat_cnt;
    repeat (10) @(negedge clk);
    chk("midreset no further writes", 64'(beat_cnt - snap), 64'(0));
    chk("midreset still idle", 64'(busy), 64'(0));
    $display("midreset: busy=%0d ready=%0d", busy, wr_ready);

    // ---------------- randomized run against the byte list ----------------
    obs_q.delete();
    exp_q.delete();
    any_unal = 1'b0;
    nsent    = 0;
    for (int n = 0; n < 600; n++) begin
      ra = 17'($urandom) & 17'h1FFFE;
      if ($urandom_range(0, 15) == 0) ra[0] = 1'b1;
      rd = {16'($urandom), $urandom};
      rm = 6'($urandom);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ra;
      wr_data  = rd;
      wr_mask  = rm;
      hold     = ($urandom_range(0, 3) == 0);
      rdy      = wr_ready;
      @(posedge clk);
      if (wr_valid && rdy) begin
        if (ra[0]) any_unal = 1'b1;
        else begin
          add_exp(ra, rd, rm);
          nsent++;
        end
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    hold     = 1'b0;
    wait_idle("random", 200);
    chk("random err flag", 64'(err_unaligned), 64'(any_unal));
    $display("random: %0d aligned words accepted", nsent);
    cmp_queues("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
